// File: rtl/range_filter_pkg.sv
// Shared types and defaults for the range_filter distance smoother.
package range_filter_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_MAX_CM  = 400;
  localparam int DEF_NEAR_CM = 30;
  localparam int DEF_FAR_CM  = 40;

  // Running sum of N=2**win_log2 entries of dist_w bits cannot exceed this width.
  function automatic int sum_width(input int dist_w, input int win_log2);
    return dist_w + win_log2;
  endfunction

endpackage

// File: rtl/range_filter_median3.sv
// 3-tap median prefilter: registered median of the last three accepted samples,
// passing the raw sample through until three are held.
module median3 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] din,
  output logic         out_valid,
  output logic [W-1:0] dout
);

  logic [W-1:0] s0_q, s1_q;
  logic [1:0]   cnt_q;

  function automatic logic [W-1:0] med(input logic [W-1:0] a, b, c);
    logic [W-1:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q      <= '0;
      s1_q      <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (flush) begin
      s0_q      <= '0;
      s1_q      <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s0_q <= din;
        s1_q <= s0_q;
        if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
        dout <= (cnt_q >= 2'd2) ? med(din, s0_q, s1_q) : din;
      end
    end
  end

endmodule

// File: rtl/range_filter.sv
// Range-checking moving-average filter for ultrasonic distance samples.
// Define RANGE_FILTER_MEDIAN3_EN to insert a 3-tap median prefilter (+1 cycle latency).
module range_filter
  import range_filter_pkg::*;
#(
  parameter int DIST_W    = 12,
  parameter int WIN_LOG2  = 2,
  parameter int MAX_CM    = DEF_MAX_CM,
  parameter int NEAR_CM   = DEF_NEAR_CM,
  parameter int FAR_CM    = DEF_FAR_CM,
  parameter int REJ_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  output logic [DIST_W-1:0] filt_dist,
  output logic              filt_valid,
  output logic              obstacle,
  output logic              sample_err,
  output logic              sensor_fault,
  output state_e            state
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = sum_width(DIST_W, WIN_LOG2);
  localparam int REJ_W = $clog2(REJ_LIMIT + 1);
  localparam logic [DIST_W-1:0]   MAX_V    = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0]   NEAR_V   = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0]   FAR_V    = DIST_W'(FAR_CM);
  localparam logic [REJ_W-1:0]    REJ_MAX  = REJ_W'(REJ_LIMIT);
  localparam logic [REJ_W-1:0]    REJ_LAST = REJ_W'(REJ_LIMIT - 1);
  localparam logic [WIN_LOG2:0]   FILL_LAST = (WIN_LOG2 + 1)'(N - 1);

  state_e state_q, state_d;

  logic [DIST_W-1:0]   win_q [N];
  logic [SUM_W-1:0]    sum_q;
  logic [WIN_LOG2-1:0] ptr_q;
  logic [WIN_LOG2:0]   fill_q;
  logic [REJ_W-1:0]    rej_cnt_q;
  logic                upd_q;

  logic              take, in_range, accept, reject, flush;
  logic              win_valid;
  logic [DIST_W-1:0] win_data;
  logic [DIST_W-1:0] avg;

  assign take     = en & dist_valid;
  assign in_range = (dist_in != '0) && (dist_in <= MAX_V);
  assign accept   = take & in_range;
  assign reject   = take & ~in_range;
  assign flush    = reject && (rej_cnt_q >= REJ_LAST);
  assign avg      = sum_q[SUM_W-1:WIN_LOG2];
  assign state    = state_q;

`ifdef RANGE_FILTER_MEDIAN3_EN
  median3 #(.W(DIST_W)) u_median3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (accept),
    .din       (dist_in),
    .out_valid (win_valid),
    .dout      (win_data)
  );
`else
  assign win_valid = accept;
  assign win_data  = dist_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = FILL;
    else if (win_valid && state_q == FILL && fill_q == FILL_LAST)
      state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) win_q[i] <= '0;
      sum_q        <= '0;
      ptr_q        <= '0;
      fill_q       <= '0;
      rej_cnt_q    <= '0;
      upd_q        <= 1'b0;
      sample_err   <= 1'b0;
      sensor_fault <= 1'b0;
      filt_dist    <= '0;
      filt_valid   <= 1'b0;
      obstacle     <= 1'b0;
    end else begin
      sample_err <= reject;
      if (reject) begin
        if (rej_cnt_q != REJ_MAX) rej_cnt_q <= rej_cnt_q + 1'b1;
        if (flush) sensor_fault <= 1'b1;
      end else if (accept) begin
        rej_cnt_q    <= '0;
        sensor_fault <= 1'b0;
      end

      // Entries must be zeroed on flush so the running sum stays exact afterwards.
      if (flush) begin
        for (int i = 0; i < N; i++) win_q[i] <= '0;
        sum_q  <= '0;
        ptr_q  <= '0;
        fill_q <= '0;
      end else if (win_valid) begin
        win_q[ptr_q] <= win_data;
        sum_q        <= sum_q + SUM_W'(win_data) - SUM_W'(win_q[ptr_q]);
        ptr_q        <= ptr_q + 1'b1;
        if (state_q == FILL) fill_q <= fill_q + 1'b1;
      end

      upd_q      <= win_valid & ~flush;
      filt_valid <= upd_q && (state_q == RUN);
      if (upd_q && state_q == RUN) begin
        filt_dist <= avg;
        if (avg < NEAR_V)      obstacle <= 1'b1;
        else if (avg >= FAR_V) obstacle <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_range_filter.sv
// Directed bench for range_filter (default build, 2-cycle latency).
module tb_range_filter;
  import range_filter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, dist_valid;
  logic [11:0] dist_in;
  logic [11:0] filt_dist;
  logic        filt_valid, obstacle, sample_err, sensor_fault;
  state_e      state;

  int compared   = 0;
  int mismatched = 0;

  range_filter dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .dist_in      (dist_in),
    .dist_valid   (dist_valid),
    .filt_dist    (filt_dist),
    .filt_valid   (filt_valid),
    .obstacle     (obstacle),
    .sample_err   (sample_err),
    .sensor_fault (sensor_fault),
    .state        (state)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d);
    dist_in    = d;
    dist_valid = 1'b1;
    step();
    dist_valid = 1'b0;
  endtask

  // Accepted isolated sample: checks cycle 1 flags and cycle 2 outputs.
  task automatic acc(input string tag, input logic [11:0] d, input logic exp_fv,
                     input logic [11:0] exp_fd, input logic exp_obs);
    send(d);
    check({tag, "_err"}, sample_err, 0);
    check({tag, "_fault"}, sensor_fault, 0);
    step();
    check({tag, "_fv"}, filt_valid, exp_fv);
    check({tag, "_fd"}, filt_dist, exp_fd);
    check({tag, "_obs"}, obstacle, exp_obs);
  endtask

  task automatic rej(input string tag, input logic [11:0] d, input logic exp_fault,
                     input logic [11:0] exp_fd);
    send(d);
    check({tag, "_err"}, sample_err, 1);
    check({tag, "_fault"}, sensor_fault, exp_fault);
    step();
    check({tag, "_fv"}, filt_valid, 0);
    check({tag, "_fd"}, filt_dist, exp_fd);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dist_valid = 1'b0; dist_in = '0;
    step(); step();
    check("rst_fd", filt_dist, 0);
    check("rst_fv", filt_valid, 0);
    check("rst_obs", obstacle, 0);
    check("rst_err", sample_err, 0);
    check("rst_fault", sensor_fault, 0);
    check("rst_state", state, FILL);
    rst = 1'b0;
    step();

    // Fill with 100s
    acc("fill0", 100, 0, 0, 0);
    acc("fill1", 100, 0, 0, 0);
    acc("fill2", 100, 0, 0, 0);
    acc("fill3", 100, 1, 100, 0);
    check("fill_state", state, RUN);

    // Slide towards obstacle
    acc("near0", 20, 1, 80, 0);
    acc("near1", 20, 1, 60, 0);
    acc("near2", 20, 1, 40, 0);
    acc("near3", 20, 1, 20, 1);

    // Hysteresis release
    acc("far0", 45, 1, 26, 1);
    acc("far1", 45, 1, 32, 1);
    acc("far2", 45, 1, 38, 1);
    acc("far3", 45, 1, 45, 0);

    // Rejects, then fault and flush
    rej("rej0", 0, 0, 45);
    rej("rej1", 401, 0, 45);
    rej("rej2", 500, 0, 45);
    rej("rej3", 0, 1, 45);
    check("flush_state", state, FILL);
    check("flush_obs", obstacle, 0);

    acc("rec0", 50, 0, 45, 0);
    acc("rec1", 50, 0, 45, 0);
    acc("rec2", 50, 0, 45, 0);
    acc("rec3", 50, 1, 50, 0);

    // Back-to-back from a fresh window
    rst = 1'b1; step(); rst = 1'b0; step();
    dist_valid = 1'b1;
    dist_in = 10; step();
    dist_in = 20; step(); check("b2b_a10", filt_valid, 0);
    dist_in = 30; step(); check("b2b_a20", filt_valid, 0);
    dist_in = 40; step(); check("b2b_a30", filt_valid, 0);
    dist_valid = 1'b0; step();
    check("b2b_a40_fv", filt_valid, 1);
    check("b2b_a40_fd", filt_dist, 25);
    check("b2b_a40_obs", obstacle, 1);
    step();
    check("b2b_a_idle", filt_valid, 0);
    check("b2b_a_state", state, RUN);

    // Back-to-back in RUN, average between thresholds holds obstacle
    dist_valid = 1'b1;
    dist_in = 30; step();
    dist_in = 35; step();
    check("b2b_b0_fv", filt_valid, 1); check("b2b_b0_fd", filt_dist, 30);
    check("b2b_b0_obs", obstacle, 1);
    dist_in = 35; step();
    check("b2b_b1_fv", filt_valid, 1); check("b2b_b1_fd", filt_dist, 33);
    dist_in = 40; step();
    check("b2b_b2_fv", filt_valid, 1); check("b2b_b2_fd", filt_dist, 35);
    dist_valid = 1'b0; step();
    check("b2b_b3_fv", filt_valid, 1); check("b2b_b3_fd", filt_dist, 35);
    check("b2b_b3_obs", obstacle, 1);

    // Strobes while disabled are ignored
    en = 1'b0; dist_valid = 1'b1; dist_in = 5; step();
    check("en_acc_err", sample_err, 0);
    dist_in = 0; step();
    check("en_rej_err", sample_err, 0);
    check("en_fv0", filt_valid, 0);
    dist_valid = 1'b0; en = 1'b1; step();
    check("en_fv1", filt_valid, 0);
    check("en_err", sample_err, 0);
    check("en_fd", filt_dist, 35);

    // Asynchronous reset with a sample in flight
    send(100);
    rst = 1'b1;
    #1;
    check("mid_fd", filt_dist, 0);
    check("mid_fv", filt_valid, 0);
    check("mid_obs", obstacle, 0);
    check("mid_fault", sensor_fault, 0);
    check("mid_err", sample_err, 0);
    check("mid_state", state, FILL);
    step();
    check("mid_fv_hold", filt_valid, 0);
    rst = 1'b0;
    step();
    check("mid_fv_after", filt_valid, 0);
    check("mid_state_after", state, FILL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
